cs_micro_sequencer: RTL and testbench

Microprogram sequencer for the control-store datapath. It holds the microprogram counter (MPC) and computes the next micro-address from the current microinstruction's COND/ADDRESS fields, the ALU flags and the dispatch opcode. It drives the control-store address and the MIR load strobe. It stalls on memory RD/WR until the memory is ready, supports CALL/RET through a small return stack, and halts on fatal sequencing errors.

---
 rtl/cs_micro_sequencer.sv | 153 +++++++++++++++
 tb/tb_cs_micro_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cs_micro_sequencer.sv
// Microprogram sequencer: holds the MPC, computes the next control-store address,
// stalls on memory access, and supports CALL/RET through a small return stack.
module cs_micro_sequencer #(
   parameter int unsigned ADDR_W      = 11,
   parameter int unsigned COND_W      = 3,
   parameter int unsigned OPC_W       = 8,
   parameter int unsigned STACK_DEPTH = 4
) (
   input  logic                         CS_MIR_CLOCK_50,
   input  logic                         CS_MIR_RESET_InHigh,
   input  logic                         CS_SEQ_enable_InHigh,
   input  logic [COND_W-1:0]            CS_SEQ_COND_data_InBUS,
   input  logic [ADDR_W-1:0]            CS_SEQ_ADDRESS_data_InBUS,
   input  logic                         CS_SEQ_RD_data_In,
   input  logic                         CS_SEQ_WR_data_In,
   input  logic                         CS_SEQ_N_flag_In,
   input  logic                         CS_SEQ_Z_flag_In,
   input  logic                         CS_SEQ_C_flag_In,
   input  logic [OPC_W-1:0]             CS_SEQ_OPCODE_data_InBUS,
   input  logic                         CS_SEQ_MEMREADY_In,
   output logic [ADDR_W-1:0]            CS_SEQ_NEXT_data_OutBUS,
   output logic [ADDR_W-1:0]            CS_SEQ_MPC_data_OutBUS,
   output logic                         CS_SEQ_MIR_load_OutLow,
   output logic                         CS_SEQ_stall_Out,
   output logic                         CS_SEQ_halted_Out,
   output logic [1:0]                   CS_SEQ_error_OutBUS,
   output logic [$clog2(STACK_DEPTH):0] CS_SEQ_sp_OutBUS
);

   localparam int unsigned IDX_W = $clog2(STACK_DEPTH);
   localparam int unsigned SP_W  = IDX_W + 1;

   typedef enum logic [1:0] {ST_START, ST_RUN, ST_MEM_WAIT, ST_HALT} state_t;

   state_t            state, state_d;
   logic [ADDR_W-1:0] mpc, mpc_inc, cond_next, next_addr;
   logic [ADDR_W-1:0] stack [STACK_DEPTH];
   logic [SP_W-1:0]   sp;
   logic [1:0]        error, error_d, cond_err;
   logic              cond_push, cond_pop, push, pop, take_cond, load_n;
   logic              stall, halted;

   assign mpc_inc = mpc + ADDR_W'(1);

   // Branch target and stack action selected by COND; errors are detected here
   always_comb begin
      cond_next = mpc_inc;
      cond_err  = 2'd0;
      cond_push = 1'b0;
      cond_pop  = 1'b0;
      case (CS_SEQ_COND_data_InBUS)
         COND_W'(1): if (CS_SEQ_N_flag_In) cond_next = CS_SEQ_ADDRESS_data_InBUS;
         COND_W'(2): if (CS_SEQ_Z_flag_In) cond_next = CS_SEQ_ADDRESS_data_InBUS;
         COND_W'(3): cond_next = CS_SEQ_ADDRESS_data_InBUS;
         COND_W'(4): if (CS_SEQ_C_flag_In) cond_next = CS_SEQ_ADDRESS_data_InBUS;
         COND_W'(5): begin
            if (sp == SP_W'(STACK_DEPTH)) begin
               cond_err = 2'd1;
            end else begin
               cond_next = CS_SEQ_ADDRESS_data_InBUS;
               cond_push = 1'b1;
            end
         end
         COND_W'(6): begin
            if (sp == '0) begin
               cond_err = 2'd2;
            end else begin
               cond_next = stack[IDX_W'(sp - SP_W'(1))];
               cond_pop  = 1'b1;
            end
         end
         COND_W'(7): cond_next = CS_SEQ_ADDRESS_data_InBUS | ADDR_W'(CS_SEQ_OPCODE_data_InBUS);
         default: ;
      endcase
   end

   // Sequencing decision: frozen (NEXT=MPC, no load) unless a step is taken
   always_comb begin
      next_addr = mpc;
      load_n    = 1'b1;
      state_d   = state;
      error_d   = error;
      take_cond = 1'b0;
      push      = 1'b0;
      pop       = 1'b0;
      case (state)
         ST_START: begin
            next_addr = '0;
            load_n    = 1'b0;
            state_d   = ST_RUN;
         end
         ST_RUN: begin
            if (CS_SEQ_enable_InHigh) begin
               if (CS_SEQ_RD_data_In && CS_SEQ_WR_data_In) begin
                  state_d = ST_HALT;
                  error_d = 2'd3;
               end else if ((CS_SEQ_RD_data_In || CS_SEQ_WR_data_In) && !CS_SEQ_MEMREADY_In) begin
                  state_d = ST_MEM_WAIT;
               end else begin
                  take_cond = 1'b1;
               end
            end
         end
         ST_MEM_WAIT: take_cond = CS_SEQ_enable_InHigh && CS_SEQ_MEMREADY_In;
         default: ;
      endcase
      if (take_cond) begin
         if (cond_err != 2'd0) begin
            state_d = ST_HALT;
            error_d = cond_err;
         end else begin
            next_addr = cond_next;
            load_n    = 1'b0;
            state_d   = ST_RUN;
            push      = cond_push;
            pop       = cond_pop;
         end
      end
   end

   always_ff @(posedge CS_MIR_CLOCK_50 or posedge CS_MIR_RESET_InHigh) begin
      if (CS_MIR_RESET_InHigh) begin
         state  <= ST_START;
         mpc    <= '0;
         sp     <= '0;
         error  <= 2'd0;
         stall  <= 1'b0;
         halted <= 1'b0;
      end else begin
         state  <= state_d;
         error  <= error_d;
         stall  <= (state_d == ST_MEM_WAIT);
         halted <= (state_d == ST_HALT);
         if (!load_n) mpc <= next_addr;
         if (push)     sp <= sp + SP_W'(1);
         else if (pop) sp <= sp - SP_W'(1);
      end
   end

   // Stack storage needs no reset; entries above sp are never read
   always_ff @(posedge CS_MIR_CLOCK_50) begin
      if (push) stack[sp[IDX_W-1:0]] <= mpc_inc;
   end

   assign CS_SEQ_NEXT_data_OutBUS = next_addr;
   assign CS_SEQ_MPC_data_OutBUS  = mpc;
   assign CS_SEQ_MIR_load_OutLow  = load_n;
   assign CS_SEQ_stall_Out        = stall;
   assign CS_SEQ_halted_Out       = halted;
   assign CS_SEQ_error_OutBUS     = error;
   assign CS_SEQ_sp_OutBUS        = sp;

endmodule

// File: tb/tb_cs_micro_sequencer.sv
// Bench for cs_micro_sequencer: directed scenarios plus randomized stimulus
// compared cycle by cycle against a queue-based reference model.
module tb_cs_micro_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b1, rd = 1'b0, wr = 1'b0, nf = 1'b0, zf = 1'b0, cf = 1'b0, mr = 1'b1;
   logic [2:0]  cond = '0;
   logic [10:0] addr = '0;
   logic [7:0]  opc = '0;
   logic [10:0] dut_next, dut_mpc;
   logic        dut_load, dut_stall, dut_halted;
   logic [1:0]  dut_err;
   logic [2:0]  dut_sp;

   int checks = 0;
   int errors = 0;

   cs_micro_sequencer dut (
      .CS_MIR_CLOCK_50          (clk),
      .CS_MIR_RESET_InHigh      (rst),
      .CS_SEQ_enable_InHigh     (en),
      .CS_SEQ_COND_data_InBUS   (cond),
      .CS_SEQ_ADDRESS_data_InBUS(addr),
      .CS_SEQ_RD_data_In        (rd),
      .CS_SEQ_WR_data_In        (wr),
      .CS_SEQ_N_flag_In         (nf),
      .CS_SEQ_Z_flag_In         (zf),
      .CS_SEQ_C_flag_In         (cf),
      .CS_SEQ_OPCODE_data_InBUS (opc),
      .CS_SEQ_MEMREADY_In       (mr),
      .CS_SEQ_NEXT_data_OutBUS  (dut_next),
      .CS_SEQ_MPC_data_OutBUS   (dut_mpc),
      .CS_SEQ_MIR_load_OutLow   (dut_load),
      .CS_SEQ_stall_Out         (dut_stall),
      .CS_SEQ_halted_Out        (dut_halted),
      .CS_SEQ_error_OutBUS      (dut_err),
      .CS_SEQ_sp_OutBUS         (dut_sp)
   );

   always #10 clk = ~clk;

   // Reference model: mode 0 start, 1 run, 2 waiting on memory, 3 halted
   int m_mode, m_mpc, m_err;
   int m_stk[$];
   int e_next, e_load, n_mode, n_err, n_act, m_inc;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_mpc = 0; m_err = 0;
      m_stk.delete();
   endtask

   task automatic model_eval();
      int tgt, e;
      bit take;
      e_next = m_mpc; e_load = 1; n_mode = m_mode; n_err = m_err; n_act = 0;
      m_inc = (m_mpc + 1) % 2048;
      take = 0;
      if (m_mode == 0) begin
         e_next = 0; e_load = 0; n_mode = 1;
      end else if (m_mode == 1 && en) begin
         if (rd && wr) begin n_mode = 3; n_err = 3; end
         else if ((rd || wr) && !mr) n_mode = 2;
         else take = 1;
      end else if (m_mode == 2 && en && mr) begin
         take = 1;
      end
      if (take) begin
         tgt = m_inc; e = 0;
         case (cond)
            3'd1: if (nf) tgt = addr;
            3'd2: if (zf) tgt = addr;
            3'd3: tgt = addr;
            3'd4: if (cf) tgt = addr;
            3'd5: if (m_stk.size() == 4) e = 1; else begin tgt = addr; n_act = 1; end
            3'd6: if (m_stk.size() == 0) e = 2; else begin tgt = m_stk[$]; n_act = 2; end
            3'd7: tgt = addr | opc;
            default: ;
         endcase
         if (e != 0) begin
            n_mode = 3; n_err = e; n_act = 0;
         end else begin
            e_next = tgt; e_load = 0; n_mode = 1;
         end
      end
   endtask

   task automatic model_commit();
      if (e_load == 0) m_mpc = e_next;
      if (n_act == 1) m_stk.push_back(m_inc);
      if (n_act == 2) void'(m_stk.pop_back());
      m_mode = n_mode;
      m_err  = n_err;
   endtask

   task automatic check_regs();
      chk("mpc",    32'(dut_mpc),    m_mpc);
      chk("sp",     32'(dut_sp),     m_stk.size());
      chk("error",  32'(dut_err),    m_err);
      chk("stall",  32'(dut_stall),  (m_mode == 2) ? 1 : 0);
      chk("halted", 32'(dut_halted), (m_mode == 3) ? 1 : 0);
   endtask

   // Called at negedge after inputs are driven
   task automatic step();
      #1;
      model_eval();
      check_regs();
      chk("next", 32'(dut_next), e_next);
      chk("load", 32'(dut_load), e_load);
   endtask

   task automatic clock();
      @(posedge clk);
      model_commit();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      model_reset();
      check_regs();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic jump_to(input logic [10:0] a);
      cond = 3'd3; addr = a; rd = 0; wr = 0; en = 1;
      step(); clock();
   endtask

   initial begin
      int m0, halt_cnt;
      model_reset();
      @(negedge clk);
      do_reset();

      // Start-up and sequential advance
      cond = 3'd0;
      step();
      chk("start_next", 32'(dut_next), 0);
      chk("start_load", 32'(dut_load), 0);
      clock();
      for (int i = 0; i < 4; i++) begin
         step(); chk("seq_mpc", 32'(dut_mpc), i); clock();
      end

      // Wrap at top of address space
      jump_to(11'h7FF);
      cond = 3'd0;
      step();
      chk("wrap_mpc", 32'(dut_mpc), 32'h7FF);
      chk("wrap_next", 32'(dut_next), 0);
      clock();

      // Conditional branches taken and not taken
      cond = 3'd2; addr = 11'h155; zf = 1;
      step(); chk("jz_taken", 32'(dut_next), 32'h155); clock();
      jump_to(11'h010);
      cond = 3'd2; addr = 11'h155; zf = 0;
      step(); chk("jz_fall", 32'(dut_next), 32'h011); clock();
      cond = 3'd1; nf = 1;
      step(); chk("jn_taken", 32'(dut_next), 32'h155); clock();
      cond = 3'd4; cf = 0;
      step(); chk("jc_fall", 32'(dut_next), 32'h156); clock();

      // Dispatch
      cond = 3'd7; addr = 11'h400; opc = 8'h3C;
      step(); chk("dispatch", 32'(dut_next), 32'h43C); clock();

      // CALL then RET
      jump_to(11'h020);
      cond = 3'd5; addr = 11'h100;
      step(); chk("call_next", 32'(dut_next), 32'h100); clock();
      cond = 3'd6;
      step(); chk("call_sp", 32'(dut_sp), 1); chk("ret_next", 32'(dut_next), 32'h021); clock();
      cond = 3'd0;
      step(); chk("ret_sp", 32'(dut_sp), 0); clock();

      // Memory stall for three cycles, then ready
      rd = 1; mr = 0;
      m0 = m_mpc;
      for (int i = 0; i < 3; i++) begin
         step(); chk("stall_next", 32'(dut_next), m0); chk("stall_load", 32'(dut_load), 1); clock();
      end
      mr = 1;
      step();
      chk("stall_flag", 32'(dut_stall), 1);
      chk("ready_next", 32'(dut_next), (m0 + 1) % 2048);
      chk("ready_load", 32'(dut_load), 0);
      clock();
      rd = 0;
      step(); chk("stall_drop", 32'(dut_stall), 0); clock();

      // Enable low while waiting on memory holds the wait
      wr = 1; mr = 0;
      step(); clock();
      en = 0; mr = 1;
      step(); chk("en_hold_load", 32'(dut_load), 1); clock();
      step(); chk("en_hold_stall", 32'(dut_stall), 1); clock();
      en = 1;
      step(); clock();
      wr = 0;

      // Stack overflow on fifth nested CALL
      cond = 3'd5; addr = 11'h200;
      for (int i = 0; i < 5; i++) begin step(); clock(); end
      step();
      chk("ovf_halted", 32'(dut_halted), 1);
      chk("ovf_error", 32'(dut_err), 1);
      chk("ovf_sp", 32'(dut_sp), 4);
      clock();

      // RD/WR conflict
      do_reset();
      cond = 3'd0;
      step(); clock();
      rd = 1; wr = 1;
      step(); clock();
      step(); chk("conf_error", 32'(dut_err), 3); chk("conf_halted", 32'(dut_halted), 1); clock();
      rd = 0; wr = 0;

      // Stack underflow stays halted until reset
      do_reset();
      step(); clock();
      cond = 3'd6;
      step(); clock();
      m0 = m_mpc;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("unf_error", 32'(dut_err), 2);
         chk("unf_next", 32'(dut_next), m0);
         clock();
      end
      do_reset();
      chk("unf_cleared", 32'(dut_halted), 0);

      // Randomized run, with occasional resets (including mid-stall or mid-call)
      halt_cnt = 0;
      for (int i = 0; i < 4000; i++) begin
         en   = ($urandom_range(0, 7) != 0);
         rd   = ($urandom_range(0, 5) == 0);
         wr   = ($urandom_range(0, 5) == 0);
         mr   = ($urandom_range(0, 2) != 0);
         nf   = 1'($urandom);
         zf   = 1'($urandom);
         cf   = 1'($urandom);
         cond = 3'($urandom);
         addr = 11'($urandom);
         opc  = 8'($urandom);
         halt_cnt = (m_mode == 3) ? halt_cnt + 1 : 0;
         if ($urandom_range(0, 59) == 0 || halt_cnt > 4) begin
            do_reset();
            halt_cnt = 0;
         end
         step();
         clock();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
